// File: rtl/if_fetch_unit_if.sv
// Memory read bus between the fetch unit and the instruction memory.
// The fetch unit issues word reads with req/addr; memory answers with a one-cycle ack carrying rdata.
interface if_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-per-line instruction cache,
// miss handling over a req/ack memory bus, and branch/jump redirects.
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          INDEX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  if_fetch_unit_if.master      mem,
  output logic [31:0]          pc_out,
  output logic [31:0]          pc_plus4,
  output logic [31:0]          instr,
  output logic                 hit
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic                    mem_req_q, mem_req_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [31:0]             pend_pc_q, pend_pc_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_arr_q  [LINES];
  logic [31:0]             data_arr_q [LINES];

  logic [INDEX_BITS-1:0]   idx_s;
  logic [TAG_W-1:0]        tag_s;
  logic [31:0]             redirect_tgt_s;
  logic                    hit_s;
  logic                    fill_s;

  assign idx_s          = pc_q[INDEX_BITS+1:2];
  assign tag_s          = pc_q[31:INDEX_BITS+2];
  assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;

  // Lookup is only trusted in IDLE; during a fill the line under the PC is in flux.
  assign hit_s = (state_q == S_IDLE) && valid_q[idx_s] && (tag_arr_q[idx_s] == tag_s);

  assign hit          = hit_s;
  assign instr        = hit_s ? data_arr_q[idx_s] : 32'h0000_0000;
  assign pc_out       = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

  // Next-state, PC update and fill decision.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    fill_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = redirect_tgt_s;
        end else if (hit_s && !stall) begin
          pc_d = pc_q + 32'd4;
        end else if (hit_s) begin
          pc_d = pc_q;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q & 32'hFFFF_FFFC;
          state_d    = S_MISS;
        end
      end
      S_MISS: begin
        if (mem.mem_ack) begin
          // The fill always lands; a redirect arriving with the ack beats an older pending one.
          fill_s       = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = S_IDLE;
          pend_valid_d = 1'b0;
          if (redirect) begin
            pc_d = redirect_tgt_s;
          end else if (pend_valid_q) begin
            pc_d = pend_pc_q;
          end else begin
            pc_d = pc_q;
          end
        end else if (redirect) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_tgt_s;
        end else begin
          pend_valid_d = pend_valid_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control state, PC and valid bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0000_0000;
      valid_q      <= {LINES{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      if (fill_s) begin
        valid_q[idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_arr_q[idx_s]  <= tag_s;
      data_arr_q[idx_s] <= mem.mem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: drives inputs and samples outputs on the falling edge.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        hit;
  int          n_total = 0;
  int          n_pass  = 0;

  localparam logic [31:0] D0 = 32'h2008_0005;
  localparam logic [31:0] D4 = 32'h1111_0004;
  localparam logic [31:0] D8 = 32'h2222_0008;
  localparam logic [31:0] DC = 32'h3333_000C;

  if_fetch_unit_if mem_bus ();

  if_fetch_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem         (mem_bus),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .hit         (hit)
  );

  always #5 clk = ~clk;

  task automatic fill(input logic [31:0] data);
    for (int i = 0; i < 20 && mem_bus.mem_req !== 1'b1; i++) @(negedge clk);
    n_total++; if (mem_bus.mem_req !== 1'b1) $display("FAIL fill_wait_req got %b exp 1", mem_bus.mem_req); else n_pass++;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = data;
    @(negedge clk);
    mem_bus.mem_ack   = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_total++; if (pc_out !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc_out); else n_pass++;
    n_total++; if (hit !== 1'b0) $display("FAIL rst_hit got %b exp 0", hit); else n_pass++;
    n_total++; if (mem_bus.mem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", mem_bus.mem_req); else n_pass++;
    n_total++; if (mem_bus.mem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", mem_bus.mem_addr); else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
    n_total++; if (mem_bus.mem_req !== 1'b1) $display("FAIL first_miss_req got %b exp 1", mem_bus.mem_req); else n_pass++;
    n_total++; if (mem_bus.mem_addr !== 32'h0) $display("FAIL first_miss_addr got %h exp 0", mem_bus.mem_addr); else n_pass++;
    n_total++; if (hit !== 1'b0) $display("FAIL first_miss_hit got %b exp 0", hit); else n_pass++;
    fill(D0);
    n_total++; if (hit !== 1'b1) $display("FAIL first_fill_hit got %b exp 1", hit); else n_pass++;
    n_total++; if (instr !== D0) $display("FAIL first_fill_instr got %h exp %h", instr, D0); else n_pass++;
    n_total++; if (pc_plus4 !== 32'h4) $display("FAIL first_fill_pc4 got %h exp 4", pc_plus4); else n_pass++;
    n_total++; if (mem_bus.mem_req !== 1'b0) $display("FAIL first_fill_req got %b exp 0", mem_bus.mem_req); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_out !== 32'h4) $display("FAIL adv_pc got %h exp 4", pc_out); else n_pass++;
    n_total++; if (hit !== 1'b0) $display("FAIL adv_hit got %b exp 0", hit); else n_pass++;
    @(negedge clk);
    n_total++; if (mem_bus.mem_req !== 1'b1) $display("FAIL second_miss_req got %b exp 1", mem_bus.mem_req); else n_pass++;
    n_total++; if (mem_bus.mem_addr !== 32'h4) $display("FAIL second_miss_addr got %h exp 4", mem_bus.mem_addr); else n_pass++;
  endtask

  task automatic test_warm_loop;
    logic [31:0] exp_d [4];
    exp_d[0] = D0; exp_d[1] = D4; exp_d[2] = D8; exp_d[3] = DC;
    stall = 1'b1;
    fill(D4);
    do_redirect(32'h8);
    fill(D8);
    do_redirect(32'hC);
    fill(DC);
    do_redirect(32'h0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (pc_out !== 32'(4 * i)) $display("FAIL warm_pc[%0d] got %h exp %h", i, pc_out, 32'(4 * i)); else n_pass++;
      n_total++; if (hit !== 1'b1) $display("FAIL warm_hit[%0d] got %b exp 1", i, hit); else n_pass++;
      n_total++; if (instr !== exp_d[i]) $display("FAIL warm_instr[%0d] got %h exp %h", i, instr, exp_d[i]); else n_pass++;
      n_total++; if (mem_bus.mem_req !== 1'b0) $display("FAIL warm_req[%0d] got %b exp 0", i, mem_bus.mem_req); else n_pass++;
      @(negedge clk);
    end
    n_total++; if (pc_out !== 32'h10) $display("FAIL warm_end_pc got %h exp 10", pc_out); else n_pass++;
  endtask

  task automatic test_stall;
    stall = 1'b1;
    do_redirect(32'h8);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (pc_out !== 32'h8) $display("FAIL stall_pc[%0d] got %h exp 8", i, pc_out); else n_pass++;
      n_total++; if (instr !== D8) $display("FAIL stall_instr[%0d] got %h exp %h", i, instr, D8); else n_pass++;
      @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    n_total++; if (pc_out !== 32'hC) $display("FAIL unstall_pc got %h exp c", pc_out); else n_pass++;
    n_total++; if (instr !== DC) $display("FAIL unstall_instr got %h exp %h", instr, DC); else n_pass++;
    stall = 1'b1;
  endtask

  task automatic test_redirect_idle;
    do_redirect(32'h0000_0043);
    n_total++; if (pc_out !== 32'h40) $display("FAIL redir_idle_pc got %h exp 40", pc_out); else n_pass++;
    n_total++; if (pc_plus4 !== 32'h44) $display("FAIL redir_idle_pc4 got %h exp 44", pc_plus4); else n_pass++;
    n_total++; if (hit !== 1'b0) $display("FAIL redir_idle_hit got %b exp 0", hit); else n_pass++;
  endtask

  task automatic test_redirect_miss;
    do_redirect(32'h100);
    n_total++; if (pc_out !== 32'h100) $display("FAIL rm_pc got %h exp 100", pc_out); else n_pass++;
    n_total++; if (hit !== 1'b0) $display("FAIL rm_alias_hit got %b exp 0", hit); else n_pass++;
    @(negedge clk);
    n_total++; if (mem_bus.mem_addr !== 32'h100) $display("FAIL rm_addr got %h exp 100", mem_bus.mem_addr); else n_pass++;
    do_redirect(32'h200);
    do_redirect(32'h300);
    n_total++; if (pc_out !== 32'h100) $display("FAIL rm_hold_pc got %h exp 100", pc_out); else n_pass++;
    n_total++; if (mem_bus.mem_req !== 1'b1) $display("FAIL rm_hold_req got %b exp 1", mem_bus.mem_req); else n_pass++;
    n_total++; if (mem_bus.mem_addr !== 32'h100) $display("FAIL rm_hold_addr got %h exp 100", mem_bus.mem_addr); else n_pass++;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    n_total++; if (pc_out !== 32'h300) $display("FAIL rm_ack_pc got %h exp 300", pc_out); else n_pass++;
    n_total++; if (mem_bus.mem_req !== 1'b0) $display("FAIL rm_ack_req got %b exp 0", mem_bus.mem_req); else n_pass++;
    do_redirect(32'h100);
    n_total++; if (hit !== 1'b1) $display("FAIL rm_revisit_hit got %b exp 1", hit); else n_pass++;
    n_total++; if (instr !== 32'hDEAD_BEEF) $display("FAIL rm_revisit_instr got %h exp deadbeef", instr); else n_pass++;
    do_redirect(32'h0);
    n_total++; if (hit !== 1'b0) $display("FAIL evicted_hit got %b exp 0", hit); else n_pass++;
    n_total++; if (instr !== 32'h0) $display("FAIL evicted_instr got %h exp 0", instr); else n_pass++;
  endtask

  task automatic test_redirect_with_ack;
    @(negedge clk);
    n_total++; if (mem_bus.mem_req !== 1'b1) $display("FAIL ra_req got %b exp 1", mem_bus.mem_req); else n_pass++;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFE_0000;
    do_redirect(32'h8);
    mem_bus.mem_ack = 1'b0;
    n_total++; if (pc_out !== 32'h8) $display("FAIL ra_pc got %h exp 8", pc_out); else n_pass++;
    n_total++; if (instr !== D8) $display("FAIL ra_instr got %h exp %h", instr, D8); else n_pass++;
    do_redirect(32'h0);
    n_total++; if (instr !== 32'hCAFE_0000) $display("FAIL ra_fill_instr got %h exp cafe0000", instr); else n_pass++;
  endtask

  task automatic test_reset_mid_miss;
    do_redirect(32'h500);
    @(negedge clk);
    n_total++; if (mem_bus.mem_req !== 1'b1) $display("FAIL rmm_req got %b exp 1", mem_bus.mem_req); else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_total++; if (mem_bus.mem_req !== 1'b0) $display("FAIL rmm_async_req got %b exp 0", mem_bus.mem_req); else n_pass++;
    n_total++; if (pc_out !== 32'h0) $display("FAIL rmm_async_pc got %h exp 0", pc_out); else n_pass++;
    @(negedge clk);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    rstn = 1'b1;
    do_redirect(32'h8);
    mem_bus.mem_ack = 1'b0;
    n_total++; if (hit !== 1'b0) $display("FAIL rmm_line2_hit got %b exp 0", hit); else n_pass++;
    n_total++; if (mem_bus.mem_req !== 1'b0) $display("FAIL rmm_idle_req got %b exp 0", mem_bus.mem_req); else n_pass++;
    do_redirect(32'h0);
    n_total++; if (hit !== 1'b0) $display("FAIL rmm_line0_hit got %b exp 0", hit); else n_pass++;
    fill(32'h0BAD_0000);
    n_total++; if (instr !== 32'h0BAD_0000) $display("FAIL rmm_refill_instr got %h exp 0bad0000", instr); else n_pass++;
  endtask

  task automatic test_wrap;
    do_redirect(32'hFFFF_FFFC);
    n_total++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h exp fffffffc", pc_out); else n_pass++;
    n_total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp 0", pc_plus4); else n_pass++;
  endtask

  initial begin
    rstn              = 1'b0;
    stall             = 1'b0;
    redirect          = 1'b0;
    redirect_pc       = 32'h0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    test_reset();
    test_warm_loop();
    test_stall();
    test_redirect_idle();
    test_redirect_miss();
    test_redirect_with_ack();
    test_reset_mid_miss();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Holds the PC and a small direct-mapped instruction cache (one word per line).
- Handles misses through a req/ack memory handshake and applies branch/jump redirects.
- Supplies pc_plus4, instr and hit to IF/ID; IF/ID latches only when hit=1.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- INDEX_BITS, 4, cache index width; 2**INDEX_BITS lines of one 32-bit word each.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- stall  input  1  hazard-unit hold; PC must not advance.
- redirect  input  1  taken branch/jump, single-cycle pulse.
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0.
- mem_ack  input  1  memory read data valid, single-cycle pulse.
- mem_rdata  input  32  memory read word, valid with mem_ack.
- mem_req  output  1  registered memory read request.
- mem_addr  output  32  registered word-aligned request address.
- pc_out  output  32  current PC.
- pc_plus4  output  32  pc_out + 4, modulo 2**32.
- instr  output  32  fetched word; 32'h0 (NOP) when hit=0.
- hit  output  1  instr valid this cycle.

Behaviour:
- Reset (async):
  - pc = PC_RESET; all valid bits = 0.
  - State = IDLE; mem_req = 0; mem_addr = 0.
  - pend_valid = 0; pend_pc = 0.
  - Tag/data arrays need not be reset.
- Address split:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[31:INDEX_BITS+2].
- Combinational outputs:
  - hit = (state==IDLE) && valid[index] && tag_arr[index]==tag.
  - instr = hit ? data_arr[index] : 0.
  - pc_plus4 = pc + 4; 32'hFFFF_FFFC wraps to 0.
  - All outputs settle before the following falling edge, where IF/ID samples.
- FSM, IDLE state:
  - redirect=1 → pc <= {redirect_pc[31:2],2'b00}. Takes priority over stall and over a miss; stay IDLE.
  - Else hit && !stall → pc <= pc+4.
  - Else hit && stall → hold pc.
  - Else (miss) → mem_req <= 1, mem_addr <= pc, go to MISS.
- FSM, MISS state:
  - mem_req held at 1 and mem_addr held stable until mem_ack.
  - On mem_ack: data_arr[index] <= mem_rdata; tag_arr[index] <= tag; valid[index] <= 1; mem_req <= 0; go to IDLE.
  - If pend_valid is set on that ack: pc <= pend_pc, pend_valid <= 0.
  - redirect in MISS: pend_valid <= 1, pend_pc <= aligned target. A later redirect overwrites the earlier one (last wins).
  - The outstanding fill is never aborted; the returned line is still written.
  - redirect and mem_ack in the same cycle: the fill completes and pc <= that cycle's redirect target.
  - stall has no effect in MISS.
- Latency:
  - Hit: one PC advance per cycle.
  - Miss detected at edge N: mem_req high from N.
  - Ack at edge M: hit=1 from M (or a redirect to the pending target is applied at M).
- mem_ack while IDLE is ignored, with no array write.
- Reset asserted mid-miss: return to IDLE, mem_req = 0, all lines invalid. A late ack after reset is ignored.
- One-word lines mean no partial-line state. Aliasing addresses evict each other (direct-mapped).

Test Plan:
- Reset release, PC_RESET=0:
  - pc_out=0, hit=0, mem_req=1, mem_addr=0 one edge later.
  - Ack with 32'h2008_0005 → hit=1, instr=32'h2008_0005, pc_plus4=4.
  - Next edge pc_out=4 and a new miss.
- Warm loop: addresses 0x0–0xC pre-filled, no stall.
  - pc_out steps 0,4,8,C on consecutive edges, hit=1 throughout, mem_req=0.
- Stall:
  - Hold stall=1 three cycles at pc=0x8 (hit) → pc stays 0x8, instr unchanged.
  - Release → 0xC next edge.
- Redirect in IDLE:
  - stall=1 and redirect=1 with redirect_pc=32'h0000_0043 → pc_out=0x40 next edge.
- Redirect during miss:
  - Miss at 0x100; redirect to 0x200, then 0x300, before ack.
  - Ack data 32'hDEAD_BEEF → line 0x100 valid (revisit 0x100 hits with 32'hDEAD_BEEF).
  - pc_out=0x300 at the ack edge.
- Reset mid-miss and edge cases:
  - rstn low while mem_req=1 → mem_req=0 immediately; a following mem_ack leaves every line invalid.
  - Redirect to 0xFFFF_FFFC → pc_plus4=0.
